vga_timing_pattern_gen: RTL

//  Parametrised VGA/LCD timing generator with selectable pixel source: grid mire, colour bars, solid

---
 rtl/vga_timing_pattern_gen.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/vga_timing_pattern_gen.sv
// VGA/LCD timing generator with grid / colour-bar / FIFO-stream / solid pixel sources.
// Optional macro VGA_UNDERFLOW_CNT_EN adds a saturating per-frame underflow counter port.
module vga_timing_pattern_gen #(
   parameter int HDISP     = 800,
   parameter int VDISP     = 480,
   parameter int HFP       = 40,
   parameter int HPULSE    = 48,
   parameter int HBP       = 40,
   parameter int VFP       = 13,
   parameter int VPULSE    = 3,
   parameter int VBP       = 29,
   parameter int RGB_W     = 24,
   parameter int GRID_LOG2 = 4
) (
   input  logic             pixel_clk,
   input  logic             pixel_rst,
   input  logic             enable,
   input  logic [1:0]       pattern_sel,
   input  logic [RGB_W-1:0] solid_rgb,
   input  logic [RGB_W-1:0] fifo_rdata,
   input  logic             fifo_empty,
   output logic             fifo_rd,
   output logic             hs,
   output logic             vs,
   output logic             blank,
   output logic [RGB_W-1:0] rgb,
   output logic             frame_start,
   output logic             underflow
`ifdef VGA_UNDERFLOW_CNT_EN
   ,
   output logic [15:0]      underflow_cnt
`endif
);

   localparam int HTOT = HFP + HPULSE + HBP + HDISP;
   localparam int VTOT = VFP + VPULSE + VBP + VDISP;
   localparam int HW   = $clog2(HTOT);
   localparam int VW   = $clog2(VTOT);
   localparam int BARW = HDISP / 8;
   localparam int BPW  = $clog2(BARW + 1);
   localparam int CW   = RGB_W / 3;

   localparam logic [HW-1:0]  H_LAST = HW'(HTOT - 1);
   localparam logic [VW-1:0]  V_LAST = VW'(VTOT - 1);
   localparam logic [HW-1:0]  H_PS   = HW'(HFP);
   localparam logic [HW-1:0]  H_PE   = HW'(HFP + HPULSE);
   localparam logic [HW-1:0]  H_ACT  = HW'(HFP + HPULSE + HBP);
   localparam logic [VW-1:0]  V_PS   = VW'(VFP);
   localparam logic [VW-1:0]  V_PE   = VW'(VFP + VPULSE);
   localparam logic [VW-1:0]  V_ACT  = VW'(VFP + VPULSE + VBP);
   localparam logic [BPW-1:0] BP_LAST = BPW'(BARW - 1);

   typedef enum logic [1:0] {
      PAT_GRID   = 2'd0,
      PAT_BARS   = 2'd1,
      PAT_STREAM = 2'd2,
      PAT_SOLID  = 2'd3
   } pat_e;

   logic [HW-1:0]    hcnt_q, hcnt_d;
   logic [VW-1:0]    vcnt_q, vcnt_d;
   pat_e             mode_q, mode_d;
   logic [BPW-1:0]   bar_px_q, bar_px_d;
   logic [3:0]       bar_idx_q, bar_idx_d;
   logic             hs_q, hs_d;
   logic             vs_q, vs_d;
   logic             blank_q, blank_d;
   logic [RGB_W-1:0] rgb_q, rgb_d;
   logic             frame_start_q, frame_start_d;
   logic             underflow_q, underflow_d;

   logic             active;
   logic             origin;
   logic [HW-1:0]    x;
   logic [VW-1:0]    y;
   logic [RGB_W-1:0] bar_rgb;

   assign active = (hcnt_q >= H_ACT) && (vcnt_q >= V_ACT);
   assign origin = (hcnt_q == '0) && (vcnt_q == '0);
   assign x      = hcnt_q - H_ACT;
   assign y      = vcnt_q - V_ACT;

   // Bar colour straight from the index bits: R=~idx[1], G=~idx[2], B=~idx[0]; idx>=8 is black.
   assign bar_rgb = bar_idx_q[3] ? '0 :
                    RGB_W'({{CW{~bar_idx_q[1]}}, {CW{~bar_idx_q[2]}}, {CW{~bar_idx_q[0]}}});

   assign fifo_rd = enable && active && (mode_q == PAT_STREAM) && !fifo_empty;

   always_comb begin
      hcnt_d        = hcnt_q;
      vcnt_d        = vcnt_q;
      mode_d        = mode_q;
      bar_px_d      = '0;
      bar_idx_d     = '0;
      hs_d          = 1'b1;
      vs_d          = 1'b1;
      blank_d       = 1'b0;
      rgb_d         = '0;
      frame_start_d = 1'b0;
      underflow_d   = 1'b0;

      if (!enable) begin
         hcnt_d = '0;
         vcnt_d = '0;
         mode_d = PAT_GRID;
      end else begin
         if (hcnt_q == H_LAST) begin
            hcnt_d = '0;
            vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + 1'b1;
         end else begin
            hcnt_d = hcnt_q + 1'b1;
         end

         // Mode only changes at the frame origin so a frame never mixes sources.
         if (origin) begin
            mode_d = pat_e'(pattern_sel);
         end

         if (active) begin
            if (bar_px_q == BP_LAST) begin
               bar_idx_d = bar_idx_q[3] ? bar_idx_q : bar_idx_q + 4'd1;
            end else begin
               bar_px_d  = bar_px_q + 1'b1;
               bar_idx_d = bar_idx_q;
            end
         end

         frame_start_d = origin;
         hs_d          = !((hcnt_q >= H_PS) && (hcnt_q < H_PE));
         vs_d          = !((vcnt_q >= V_PS) && (vcnt_q < V_PE));
         blank_d       = active;

         if (active) begin
            case (mode_q)
               PAT_GRID:   rgb_d = (&x[GRID_LOG2-1:0] || &y[GRID_LOG2-1:0]) ? '1 : '0;
               PAT_BARS:   rgb_d = bar_rgb;
               PAT_STREAM: begin
                  rgb_d       = fifo_empty ? '0 : fifo_rdata;
                  underflow_d = fifo_empty;
               end
               default:    rgb_d = solid_rgb;
            endcase
         end
      end
   end

   always_ff @(posedge pixel_clk or posedge pixel_rst) begin
      if (pixel_rst) begin
         hcnt_q        <= '0;
         vcnt_q        <= '0;
         mode_q        <= PAT_GRID;
         bar_px_q      <= '0;
         bar_idx_q     <= '0;
         hs_q          <= 1'b1;
         vs_q          <= 1'b1;
         blank_q       <= 1'b0;
         rgb_q         <= '0;
         frame_start_q <= 1'b0;
         underflow_q   <= 1'b0;
      end else begin
         hcnt_q        <= hcnt_d;
         vcnt_q        <= vcnt_d;
         mode_q        <= mode_d;
         bar_px_q      <= bar_px_d;
         bar_idx_q     <= bar_idx_d;
         hs_q          <= hs_d;
         vs_q          <= vs_d;
         blank_q       <= blank_d;
         rgb_q         <= rgb_d;
         frame_start_q <= frame_start_d;
         underflow_q   <= underflow_d;
      end
   end

   assign hs          = hs_q;
   assign vs          = vs_q;
   assign blank       = blank_q;
   assign rgb         = rgb_q;
   assign frame_start = frame_start_q;
   assign underflow   = underflow_q;

`ifdef VGA_UNDERFLOW_CNT_EN
   logic [15:0] ucnt_q, ucnt_d;

   // Cleared on the same edge that raises frame_start, so the last frame's total stays visible until then.
   always_comb begin
      ucnt_d = ucnt_q;
      if (enable && origin) begin
         ucnt_d = '0;
      end else if (underflow_d && (ucnt_q != 16'hFFFF)) begin
         ucnt_d = ucnt_q + 16'd1;
      end
   end

   always_ff @(posedge pixel_clk or posedge pixel_rst) begin
      if (pixel_rst) begin
         ucnt_q <= '0;
      end else begin
         ucnt_q <= ucnt_d;
      end
   end

   assign underflow_cnt = ucnt_q;
`endif

endmodule
